seven_segment_scan_decoder: RTL and testbench
=============================================

Name: seven_segment_scan_decoder

Overview:
- Receive-side counterpart to seven_segment_driver. Snoops the multiplexed display bus (anode_signals, display_out) and reconstructs the minutes and seconds values being shown.
- Used for on-chip loopback self-check of the stopwatch display path, and as a reusable checker model in benches.
- Samples each digit only after its anode and cathodes have been stable, decodes cathode patterns back to BCD, and publishes a full MM:SS frame once all four digits have been captured.

Parameters:
- SETTLE_CYCLES, 16: consecutive identical registered samples needed before a digit is captured (range 1..255).
- TIMEOUT_CYCLES, 1000000: clock cycles without any capture before scan_timeout asserts (20 ms at 50 MHz).

Ports:
- clock  input  1  50 MHz system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low; 0 forces every register to its reset value.
- anode_signals  input  4  active-low digit enables: 0111 = minutes tens, 1011 = minutes ones, 1101 = seconds tens, 1110 = seconds ones.
- display_out  input  7  active-low cathodes, bit 6..0 = segments a,b,c,d,e,f,g.
- clear_errors  input  1  synchronous, one-cycle pulse; clears the sticky error flags.
- minutes  output  7  last published minutes, 0..99.
- seconds  output  7  last published seconds, 0..99; a value above 59 also raises range_error.
- frame_valid  output  1  one-cycle pulse when minutes/seconds update.
- decode_error  output  1  sticky: illegal cathode pattern or illegal anode code seen.
- range_error  output  1  sticky: a published seconds-tens digit was greater than 5.
- scan_timeout  output  1  level: no capture for TIMEOUT_CYCLES cycles.

Behaviour:
- Reset values: minutes=0, seconds=0, frame_valid=0, decode_error=0, range_error=0, scan_timeout=0; captured mask, digit registers and all counters = 0; per-digit FSM = IDLE.
- Input stage: anode_signals and display_out are registered once (anode_q, seg_q). All decisions use the registered values, so there is one cycle of input latency.
- Anode classification: exactly one bit low = legal digit. 1111 = blank. Any other code is illegal: it sets decode_error and is treated as blank.
- FSM states:
  - IDLE: anode_q is blank or illegal. On a legal anode, go to SETTLING with stable_cnt=1.
  - SETTLING: if anode_q and seg_q equal the previous cycle, stable_cnt increments; otherwise stable_cnt=1. If anode_q becomes blank or illegal, go to IDLE. When stable_cnt reaches SETTLE_CYCLES, capture and go to HELD.
  - HELD: no further capture. Any change in anode_q or seg_q returns to SETTLING (legal anode, stable_cnt=1) or to IDLE (blank or illegal anode).
  - With SETTLE_CYCLES=1, capture happens on the first registered cycle of a legal anode.
- Capture decode, using the {a..g} patterns:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - Any other pattern: decode_error=1, digit not stored, mask bit unchanged.
  - Valid pattern: store the BCD value in that digit's register and set its mask bit.
- Recapturing a digit before the frame completes overwrites the stored value (latest wins).
- Frame publish:
  - On the cycle the mask becomes 1111, the next clock edge loads minutes = mt*10+ot and seconds = st*10+so, pulses frame_valid for 1 cycle, and clears the mask to 0000.
  - Arithmetic is 7-bit unsigned; maximum result is 99, so it never overflows.
  - Latency from the fourth capture to frame_valid is 1 cycle. minutes and seconds hold between frames.
- range_error is set at publish if st > 5. The frame is still published.
- Timeout: idle_cnt increments every cycle and resets to 0 on each capture. scan_timeout=1 while idle_cnt ≥ TIMEOUT_CYCLES; the counter saturates there. scan_timeout clears on the cycle after the next capture.
- clear_errors clears decode_error and range_error. If an error event occurs in the same cycle, the error event wins (flag stays 1).
- Reset asserted mid-frame: partial mask and stored digits are discarded; no frame_valid is generated.

Test Plan:
- Driver scanning 12:34, each digit held 40 cycles, SETTLE_CYCLES=16 -> frame_valid pulses once per full scan, minutes=12, seconds=34, no error flags.
- Seconds-ones digit glitching for 3 cycles between stable windows (cathodes 0010010 then 0000110) -> only 4 is captured; one frame gives seconds=34.
- Cathode pattern 1111111 on the minutes-tens digit -> decode_error=1, no frame_valid; after clear_errors and a clean scan of 05:09 -> frame with minutes=5, seconds=9, decode_error=0.
- Scan of 00:75 -> frame published with seconds=75 and range_error=1; anode 0011 -> decode_error=1.
- Bus held at anode 1111 for TIMEOUT_CYCLES -> scan_timeout=1 exactly at that count; first capture after it -> scan_timeout=0 the next cycle.
- reset driven to 0 after 3 of 4 digits are captured, then released and a scan of 99:59 applied -> a single frame with minutes=99, seconds=59; no earlier frame_valid.

Source files
------------

// File: rtl/seven_segment_scan_decoder.sv
// Purpose : snoop a multiplexed 4-digit 7-segment bus and rebuild the MM:SS value shown.
// Latency : 1 cycle input register, SETTLE_CYCLES to capture a digit, 1 cycle from the 4th capture to frame_valid.
// Backpress: none; a passive observer that never stalls the bus it watches.
//
// Ports:
//   clock          rising-edge system clock
//   reset          asynchronous active-low reset
//   anode_signals  active-low digit enables (0111 mt, 1011 ot, 1101 st, 1110 so)
//   display_out    active-low cathodes, [6:0] = segments a..g
//   clear_errors   one-cycle pulse clearing the sticky error flags
//   minutes        last published minutes (0..99)
//   seconds        last published seconds (0..99)
//   frame_valid    one-cycle pulse when minutes/seconds update
//   decode_error   sticky: illegal cathode pattern or anode code seen
//   range_error    sticky: a published seconds-tens digit exceeded 5
//   scan_timeout   level: no capture for TIMEOUT_CYCLES cycles
module seven_segment_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] anode_signals,
  input  logic [6:0] display_out,
  input  logic       clear_errors,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       frame_valid,
  output logic       decode_error,
  output logic       range_error,
  output logic       scan_timeout
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]        SETTLE_V  = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLING = 2'd1,
    S_HELD     = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input stage plus a one-cycle history used for the stability comparison
  // ---------------------------------------------------------------------------
  logic [3:0] anode_q, anode_p_q;
  logic [6:0] seg_q, seg_p_q;

  // Reset to the blank code so that the reset value itself is not flagged as
  // an illegal anode on the first cycle out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode_q   <= 4'hF;
      seg_q     <= 7'h7F;
      anode_p_q <= 4'hF;
      seg_p_q   <= 7'h7F;
    end else begin
      anode_q   <= anode_signals;
      seg_q     <= display_out;
      anode_p_q <= anode_q;
      seg_p_q   <= seg_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Anode classification and cathode decode
  // ---------------------------------------------------------------------------
  logic       anode_legal;
  logic       anode_illegal;
  logic [1:0] digit_idx;   // 3 = minutes tens ... 0 = seconds ones
  logic       same;
  logic       seg_ok;
  logic [3:0] seg_bcd;

  always_comb begin
    anode_legal = 1'b0;
    digit_idx   = 2'd0;
    case (anode_q)
      4'b0111: begin anode_legal = 1'b1; digit_idx = 2'd3; end
      4'b1011: begin anode_legal = 1'b1; digit_idx = 2'd2; end
      4'b1101: begin anode_legal = 1'b1; digit_idx = 2'd1; end
      4'b1110: begin anode_legal = 1'b1; digit_idx = 2'd0; end
      default: begin anode_legal = 1'b0; digit_idx = 2'd0; end
    endcase
  end

  // Anything that is neither one-hot-low nor blank is treated as blank but flagged.
  assign anode_illegal = (anode_q != 4'hF) && !anode_legal;
  assign same          = (anode_q == anode_p_q) && (seg_q == seg_p_q);

  always_comb begin
    seg_ok  = 1'b1;
    seg_bcd = 4'd0;
    case (seg_q)
      7'b0000001: seg_bcd = 4'd0;
      7'b1001111: seg_bcd = 4'd1;
      7'b0010010: seg_bcd = 4'd2;
      7'b0000110: seg_bcd = 4'd3;
      7'b1001100: seg_bcd = 4'd4;
      7'b0100100: seg_bcd = 4'd5;
      7'b0100000: seg_bcd = 4'd6;
      7'b0001111: seg_bcd = 4'd7;
      7'b0000000: seg_bcd = 4'd8;
      7'b0000100: seg_bcd = 4'd9;
      default: begin
        seg_ok  = 1'b0;
        seg_bcd = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Settle FSM: state register
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] stable_cnt_q, stable_cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      stable_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  // Settle FSM: next state
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (anode_legal) begin
          state_d      = S_SETTLING;
          stable_cnt_d = 8'd1;
        end
      end
      S_SETTLING: begin
        if (!anode_legal) begin
          state_d      = S_IDLE;
          stable_cnt_d = 8'd0;
        end else begin
          // stable_cnt_q < SETTLE_V here, so the increment cannot wrap.
          stable_cnt_d = same ? stable_cnt_q + 8'd1 : 8'd1;
        end
      end
      S_HELD: begin
        if (!anode_legal) begin
          state_d      = S_IDLE;
          stable_cnt_d = 8'd0;
        end else if (!same) begin
          state_d      = S_SETTLING;
          stable_cnt_d = 8'd1;
        end
      end
      default: begin
        state_d      = S_IDLE;
        stable_cnt_d = 8'd0;
      end
    endcase
    // Folding the threshold in here lets SETTLE_CYCLES=1 capture straight
    // from IDLE or from a HELD digit that just changed.
    if (state_d == S_SETTLING && stable_cnt_d >= SETTLE_V) begin
      state_d = S_HELD;
    end
  end

  // Settle FSM: outputs
  logic settle_evt;
  logic capture;
  logic bad_seg;

  always_comb begin
    // Entering HELD from anything other than an unchanged HELD is a settle event.
    settle_evt = (state_d == S_HELD) && !((state_q == S_HELD) && same);
    capture    = settle_evt && seg_ok;
    bad_seg    = settle_evt && !seg_ok;
  end

  // ---------------------------------------------------------------------------
  // Digit store, frame assembly, error flags, timeout
  // ---------------------------------------------------------------------------
  logic [3:0][3:0]   digit_q, digit_d;
  logic [3:0]        mask_q, mask_d;
  logic [6:0]        minutes_q, minutes_d;
  logic [6:0]        seconds_q, seconds_d;
  logic              frame_valid_q, frame_valid_d;
  logic              decode_error_q, decode_error_d;
  logic              range_error_q, range_error_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              publish;

  always_comb begin
    publish = (mask_q == 4'hF);

    // Publishing empties the mask; a capture on the same cycle starts the next frame.
    mask_d  = publish ? 4'h0 : mask_q;
    digit_d = digit_q;
    if (capture) begin
      mask_d[digit_idx]  = 1'b1;
      digit_d[digit_idx] = seg_bcd;
    end

    minutes_d     = minutes_q;
    seconds_d     = seconds_q;
    frame_valid_d = publish;
    if (publish) begin
      minutes_d = 7'(digit_q[3]) * 7'd10 + 7'(digit_q[2]);
      seconds_d = 7'(digit_q[1]) * 7'd10 + 7'(digit_q[0]);
    end

    // A new error event overrides a coincident clear.
    decode_error_d = (decode_error_q & ~clear_errors) | anode_illegal | bad_seg;
    range_error_d  = (range_error_q & ~clear_errors) | (publish && (digit_q[1] > 4'd5));

    if (capture) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q < TIMEOUT_V) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit_q        <= '0;
      mask_q         <= 4'h0;
      minutes_q      <= 7'd0;
      seconds_q      <= 7'd0;
      frame_valid_q  <= 1'b0;
      decode_error_q <= 1'b0;
      range_error_q  <= 1'b0;
      idle_cnt_q     <= '0;
    end else begin
      digit_q        <= digit_d;
      mask_q         <= mask_d;
      minutes_q      <= minutes_d;
      seconds_q      <= seconds_d;
      frame_valid_q  <= frame_valid_d;
      decode_error_q <= decode_error_d;
      range_error_q  <= range_error_d;
      idle_cnt_q     <= idle_cnt_d;
    end
  end

  assign minutes      = minutes_q;
  assign seconds      = seconds_q;
  assign frame_valid  = frame_valid_q;
  assign decode_error = decode_error_q;
  assign range_error  = range_error_q;
  assign scan_timeout = (idle_cnt_q >= TIMEOUT_V);

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Purpose : directed checks of seven_segment_scan_decoder against hand-computed MM:SS frames.
// Latency : n/a (testbench).
// Backpress: n/a (testbench).
`timescale 1ns/1ps
module tb_seven_segment_scan_decoder;

  localparam int SETTLE = 16;
  localparam int TMO    = 200;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] anode_signals;
  logic [6:0] display_out;
  logic       clear_errors;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic       frame_valid;
  logic       decode_error;
  logic       range_error;
  logic       scan_timeout;

  seven_segment_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .anode_signals(anode_signals),
    .display_out  (display_out),
    .clear_errors (clear_errors),
    .minutes      (minutes),
    .seconds      (seconds),
    .frame_valid  (frame_valid),
    .decode_error (decode_error),
    .range_error  (range_error),
    .scan_timeout (scan_timeout)
  );

  always #5 clock = ~clock;

  // Active-low a..g patterns for digits 0..9
  logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                               7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  int checks   = 0;
  int failures = 0;
  int frames   = 0;
  int doubles  = 0;
  logic fv_prev = 1'b0;

  always @(negedge clock) begin
    if (frame_valid) begin
      frames++;
      if (fv_prev) doubles++;
    end
    fv_prev = frame_valid;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called at posedge+1; drives the bus and waits n clock edges.
  task automatic show(input logic [3:0] an, input logic [6:0] sg, input int n);
    anode_signals = an;
    display_out   = sg;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic blank(input int n);
    show(4'hF, 7'h7F, n);
  endtask

  task automatic scan(input int m, input int s, input int n);
    show(4'b0111, seg_tab[m / 10], n);
    show(4'b1011, seg_tab[m % 10], n);
    show(4'b1101, seg_tab[s / 10], n);
    show(4'b1110, seg_tab[s % 10], n);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(posedge clock);
    #1;
    clear_errors = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    reset         = 1'b0;
    anode_signals = 4'hF;
    display_out   = 7'h7F;
    clear_errors  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_minutes", minutes, 0);
    chk("rst_seconds", seconds, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_decode_error", decode_error, 0);
    chk("rst_range_error", range_error, 0);
    chk("rst_scan_timeout", scan_timeout, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;

    // Clean 12:34 scans, one frame per scan
    f0 = frames;
    scan(12, 34, 40);
    chk("s1234_frames", frames - f0, 1);
    chk("s1234_minutes", minutes, 12);
    chk("s1234_seconds", seconds, 34);
    chk("s1234_decode_error", decode_error, 0);
    chk("s1234_range_error", range_error, 0);
    scan(12, 34, 40);
    chk("s1234_two_scans_frames", frames - f0, 2);

    // Seconds-ones glitch between stable windows
    f0 = frames;
    show(4'b0111, seg_tab[5], 40);
    show(4'b1011, seg_tab[6], 40);
    show(4'b1101, seg_tab[3], 40);
    show(4'b1110, seg_tab[4], 8);
    show(4'b1110, 7'b0010010, 2);
    show(4'b1110, 7'b0000110, 1);
    show(4'b1110, seg_tab[4], 40);
    chk("glitch_frames", frames - f0, 1);
    chk("glitch_minutes", minutes, 56);
    chk("glitch_seconds", seconds, 34);

    // Illegal cathode pattern on minutes tens
    f0 = frames;
    show(4'b0111, 7'h7F, 40);
    blank(4);
    chk("badseg_decode_error", decode_error, 1);
    chk("badseg_frames", frames - f0, 0);
    pulse_clear();
    chk("badseg_cleared", decode_error, 0);
    scan(5, 9, 40);
    chk("s0509_frames", frames - f0, 1);
    chk("s0509_minutes", minutes, 5);
    chk("s0509_seconds", seconds, 9);
    chk("s0509_decode_error", decode_error, 0);

    // Out-of-range seconds, illegal anode, clear vs event
    f0 = frames;
    scan(0, 75, 40);
    chk("s0075_frames", frames - f0, 1);
    chk("s0075_minutes", minutes, 0);
    chk("s0075_seconds", seconds, 75);
    chk("s0075_range_error", range_error, 1);
    chk("s0075_decode_error", decode_error, 0);
    pulse_clear();
    chk("range_cleared", range_error, 0);
    show(4'b0011, 7'h7F, 3);
    chk("anode0011_decode_error", decode_error, 1);
    pulse_clear();
    chk("clear_vs_event", decode_error, 1);
    blank(3);
    pulse_clear();
    chk("anode_err_cleared", decode_error, 0);

    // Settle boundary: 15 cycles per digit is too short, 16 is enough
    f0 = frames;
    scan(11, 11, SETTLE - 1);
    blank(5);
    chk("settle15_frames", frames - f0, 0);
    scan(22, 22, SETTLE);
    blank(5);
    chk("settle16_frames", frames - f0, 1);
    chk("settle16_minutes", minutes, 22);
    chk("settle16_seconds", seconds, 22);

    // Timeout: exact threshold, saturation, clear after capture
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst2_minutes", minutes, 0);
    @(negedge clock) reset = 1'b1;
    repeat (TMO - 1) @(posedge clock);
    #1;
    chk("timeout_before", scan_timeout, 0);
    @(posedge clock);
    #1;
    chk("timeout_at", scan_timeout, 1);
    blank(20);
    chk("timeout_saturated", scan_timeout, 1);
    show(4'b0111, seg_tab[5], SETTLE);
    chk("timeout_before_capture", scan_timeout, 1);
    @(posedge clock);
    #1;
    chk("timeout_after_capture", scan_timeout, 0);

    // Reset mid-frame discards the partial frame
    f0 = frames;
    scan(12, 34, 40);
    chk("pre_reset_frames", frames - f0, 1);
    chk("pre_reset_minutes", minutes, 12);
    f0 = frames;
    show(4'b0111, seg_tab[8], 40);
    show(4'b1011, seg_tab[8], 40);
    show(4'b1101, seg_tab[4], 40);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_minutes", minutes, 0);
    chk("midrst_seconds", seconds, 0);
    chk("midrst_frame_valid", frame_valid, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    scan(99, 59, 40);
    chk("s9959_frames", frames - f0, 1);
    chk("s9959_minutes", minutes, 99);
    chk("s9959_seconds", seconds, 59);
    chk("s9959_decode_error", decode_error, 0);
    chk("s9959_range_error", range_error, 0);

    chk("frame_valid_single_cycle", doubles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
